// File: rtl/bam_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bam_mul_pkg
// Purpose  : Shared constants, id type and partial-product keep rule for the
//            broken-array approximate multiplier (BAM) and its arbiter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bam_mul_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int H_CUT_DEF = 5;
  localparam int V_CUT_DEF = 12;
  localparam int ID_W_DEF  = $clog2(N_REQ_DEF);

  typedef logic [ID_W_DEF-1:0] id_t;

  // A partial product a[i]&b[j] survives both cuts of the broken array.
  function automatic bit bam_keep(input int i, input int j,
                                  input int h = H_CUT_DEF,
                                  input int v = V_CUT_DEF);
    return (j >= h) && ((i + j) >= v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bam_mul_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bam_mul_arbiter_if
// Purpose  : Request / response bundle of the shared BAM multiplier.
// Ports    : req_valid/req_ready/req_a/req_b  - per-requester request channel
//            rsp_valid/rsp_ready/rsp_data/rsp_id - tagged response channel
//            ops_count                          - completed response counter
//            master modport = requester/consumer side, slave = arbiter side
// Revision : 1.0 - initial release
// ============================================================================
interface bam_mul_arbiter_if
  import bam_mul_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [2*WIDTH-1:0]     rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic [15:0]            ops_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, ops_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, ops_count
  );

endinterface
`default_nettype wire

// File: rtl/bam_mul_core.sv
`default_nettype none
// ============================================================================
// Module   : bam_mul_core
// Purpose  : Combinational broken-array approximate multiplier. Kept partial
//            products are compressed row by row in a carry-save array and
//            resolved by a ripple-carry final adder.
// Ports    : a_i  in  WIDTH     operand a
//            b_i  in  WIDTH     operand b
//            p_o  out 2*WIDTH   approximate unsigned product
// Revision : 1.0 - initial release
// ============================================================================
module bam_mul_core
  import bam_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int H_CUT = H_CUT_DEF,
  parameter int V_CUT = V_CUT_DEF
) (
  input  wire logic [WIDTH-1:0]   a_i,
  input  wire logic [WIDTH-1:0]   b_i,
  output logic      [2*WIDTH-1:0] p_o
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] w_pp  [WIDTH];
  logic [PW-1:0] w_sum [WIDTH+1];
  logic [PW-1:0] w_cry [WIDTH+1];
  logic [PW-1:0] w_rc;

  // Partial-product rows; cut positions stay constant zero and fold away.
  always_comb begin
    for (int j = 0; j < WIDTH; j++) begin
      w_pp[j] = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (bam_keep(i, j, H_CUT, V_CUT)) begin
          w_pp[j][i+j] = a_i[i] & b_i[j];
        end
      end
    end
  end

  // Carry-save array: each row is a 3:2 compression of (sum, carry, row).
  // Bits shifted out of the top carry are always zero because the exact sum
  // of kept products fits in PW bits.
  always_comb begin
    w_sum[0] = '0;
    w_cry[0] = '0;
    for (int j = 0; j < WIDTH; j++) begin
      w_sum[j+1] = w_sum[j] ^ w_cry[j] ^ w_pp[j];
      w_cry[j+1] = ((w_sum[j] & w_cry[j]) | (w_sum[j] & w_pp[j]) |
                    (w_cry[j] & w_pp[j])) << 1;
    end
  end

  // Ripple-carry final adder.
  assign w_rc[0] = 1'b0;
  for (genvar k = 0; k < PW; k++) begin : g_rca
    assign p_o[k] = w_sum[WIDTH][k] ^ w_cry[WIDTH][k] ^ w_rc[k];
    if (k < PW - 1) begin : g_carry
      assign w_rc[k+1] = (w_sum[WIDTH][k] & w_cry[WIDTH][k]) |
                         (w_sum[WIDTH][k] & w_rc[k]) |
                         (w_cry[WIDTH][k] & w_rc[k]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bam_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bam_mul_arbiter
// Purpose  : Round-robin sharing of one BAM multiplier between N_REQ
//            requesters through a two-stage valid/ready pipeline
//            (S1: operands + id, S2: product + id) with a tagged response.
// Ports    : clk    in  rising-edge clock
//            rst_n  in  asynchronous active-low reset
//            bus    slave modport of bam_mul_arbiter_if (requests, response,
//                   ops_count)
// Revision : 1.0 - initial release
// ============================================================================
module bam_mul_arbiter
  import bam_mul_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int H_CUT = H_CUT_DEF,
  parameter int V_CUT = V_CUT_DEF
) (
  input wire logic          clk,
  input wire logic          rst_n,
  bam_mul_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(N_REQ);

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_a_q, s1_a_d;
  logic [WIDTH-1:0]     s1_b_q, s1_b_d;
  logic [ID_W-1:0]      s1_id_q, s1_id_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [2*WIDTH-1:0]   s2_data_q, s2_data_d;
  logic [ID_W-1:0]      s2_id_q, s2_id_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [15:0]          ops_q, ops_d;

  logic                 w_s2_load;
  logic                 w_s1_load;
  logic                 w_win_found;
  logic [ID_W-1:0]      w_win;
  logic [ID_W-1:0]      w_idx;
  logic [2*WIDTH-1:0]   w_prod;

  bam_mul_core #(
    .WIDTH (WIDTH),
    .H_CUT (H_CUT),
    .V_CUT (V_CUT)
  ) u_core (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .p_o (w_prod)
  );

  // Round-robin search: walk the requesters starting at rr_ptr, wrapping
  // explicitly so non-power-of-two N_REQ works.
  always_comb begin
    w_win       = '0;
    w_win_found = 1'b0;
    w_idx       = rr_ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_win_found && bus.req_valid[w_idx]) begin
        w_win_found = 1'b1;
        w_win       = w_idx;
      end
      w_idx = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  assign w_s2_load = s1_valid_q & (~s2_valid_q | bus.rsp_ready);
  // rst_n gates the grant so req_ready stays low while reset is held.
  assign w_s1_load = rst_n & w_win_found & (~s1_valid_q | w_s2_load);

  always_comb begin
    bus.req_ready = '0;
    if (w_s1_load) begin
      bus.req_ready[w_win] = 1'b1;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_id_d    = s2_id_q;
    rr_ptr_d   = rr_ptr_q;
    ops_d      = ops_q + {15'd0, s2_valid_q & bus.rsp_ready};

    if (w_s1_load) begin
      s1_valid_d = 1'b1;
      s1_id_d    = w_win;
      rr_ptr_d   = (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
      for (int k = 0; k < N_REQ; k++) begin
        if (w_win == ID_W'(k)) begin
          s1_a_d = bus.req_a[k*WIDTH +: WIDTH];
          s1_b_d = bus.req_b[k*WIDTH +: WIDTH];
        end
      end
    end else if (w_s2_load) begin
      s1_valid_d = 1'b0;
    end

    // S2 payload only changes on load, so it holds under backpressure.
    if (w_s2_load) begin
      s2_valid_d = 1'b1;
      s2_data_d  = w_prod;
      s2_id_d    = s1_id_q;
    end else if (bus.rsp_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
      rr_ptr_q   <= '0;
      ops_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_id_q    <= s2_id_d;
      rr_ptr_q   <= rr_ptr_d;
      ops_q      <= ops_d;
    end
  end

  assign bus.rsp_valid = s2_valid_q;
  assign bus.rsp_data  = s2_data_q;
  assign bus.rsp_id    = s2_id_q;
  assign bus.ops_count = ops_q;

endmodule
`default_nettype wire

// File: tb/tb_bam_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bam_mul_arbiter
// Purpose  : Self-checking bench for bam_mul_arbiter: directed cases plus
//            randomized traffic against a queue-based behavioural model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_bam_mul_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bam_mul_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  bam_mul_arbiter #(.N_REQ(N), .WIDTH(W), .H_CUT(5), .V_CUT(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: direct sum of the kept partial products.
  function automatic logic [15:0] bam_ref(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (j >= 5 && i + j >= 12 && a[i] && b[j]) s += (1 << (i + j));
    return 16'(s);
  endfunction

  // ---------------------------------------------------------------- model
  // The queue holds every accepted-but-unreturned request in order; k is the
  // edge index at which it was accepted (response visible after edge k+1).
  typedef struct {
    int          id;
    logic [15:0] d;
    int          k;
  } ent_t;

  ent_t        q[$];
  int          m_ptr = 0;
  logic [15:0] m_ops = '0;
  int          cyc   = 0;
  logic        exp_rv;
  logic [3:0]  exp_rdy;
  int          win;
  bit          can;
  logic [1:0]  idx;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ptr = 0;
      m_ops = '0;
    end else begin
      exp_rv = (q.size() > 0) && (cyc >= q[0].k + 1);
      chk("rsp_valid", bus.rsp_valid, exp_rv);
      if (exp_rv) begin
        chk("rsp_data", bus.rsp_data, q[0].d);
        chk("rsp_id", bus.rsp_id, q[0].id);
      end
      chk("ops_count", bus.ops_count, m_ops);
      win = -1;
      for (int k = 0; k < N; k++) begin
        idx = 2'((m_ptr + k) % N);
        if (win < 0 && bus.req_valid[idx]) win = int'(idx);
      end
      // At most two in flight; with two, room exists only if the head leaves.
      can = (q.size() <= 1) || (exp_rv && bus.rsp_ready);
      exp_rdy = '0;
      if (win >= 0 && can) exp_rdy[win] = 1'b1;
      chk("req_ready", bus.req_ready, exp_rdy);
      if (exp_rv && bus.rsp_ready) begin
        void'(q.pop_front());
        m_ops = m_ops + 16'd1;
      end
      if (exp_rdy != 0) begin
        q.push_back('{win, bam_ref(bus.req_a[win*W +: W], bus.req_b[win*W +: W]), cyc + 1});
        m_ptr = (win + 1) % N;
      end
    end
  end

  // -------------------------------------------------------------- directed
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic single(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    bus.req_a = '0; bus.req_a[7:0] = a;
    bus.req_b = '0; bus.req_b[7:0] = b;
    @(negedge clk);
    chk("single_grant", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_not_yet", bus.rsp_valid, 1'b0);
    @(negedge clk);
    chk("single_valid", bus.rsp_valid, 1'b1);
    chk("single_data", bus.rsp_data, e);
    chk("single_id", bus.rsp_id, 2'd0);
  endtask

  int          ng, hs, nacc, nemit;
  bit          seen_ffff;
  logic [15:0] hold_d;
  logic [1:0]  hold_id;

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset state, with all requesters asserting during reset.
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = 4'hF;
    @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 16'h0);
    chk("rst_rsp_id", bus.rsp_id, 2'd0);
    chk("rst_req_ready", bus.req_ready, 4'h0);
    chk("rst_ops", bus.ops_count, 16'h0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", bus.req_ready, 4'h0);

    // Single requester, hand-computed products.
    single(8'hFF, 8'hFF, 16'hB000);
    single(8'h80, 8'h80, 16'h4000);
    single(8'h0F, 8'hFF, 16'h0000);

    // All requesters, full throughput.
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_a = $urandom;
    bus.req_b = $urandom;
    ng = 0; hs = 0;
    for (int t = 0; t < 40 && hs < 8; t++) begin
      @(negedge clk);
      if ((bus.req_ready & bus.req_valid) != 0 && ng < 8) begin
        chk("rr_grant_order", int'($clog2(bus.req_ready)), ng % 4);
        ng++;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("rr_rsp_id", bus.rsp_id, hs % 4);
        hs++;
      end
    end
    chk("rr_handshakes", hs, 8);
    @(negedge clk);
    chk("rr_ops_8", bus.ops_count, 16'd8);

    // Backpressure.
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'hF;
    nacc = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if ((bus.req_ready & bus.req_valid) != 0) nacc++;
      if (t == 2) begin
        chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
        hold_d  = bus.rsp_data;
        hold_id = bus.rsp_id;
      end
    end
    chk("bp_accepts", nacc, 2);
    chk("bp_ready_zero", bus.req_ready, 4'h0);
    chk("bp_data_stable", bus.rsp_data, hold_d);
    chk("bp_id_stable", bus.rsp_id, hold_id);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    hs = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) hs++;
    end
    chk("bp_drain", hs, 2);

    // Reset with the pipeline full.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'hF;
    repeat (3) @(negedge clk);
    chk("mid_full", bus.rsp_valid, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("mid_rst_ops", bus.ops_count, 16'h0);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    nemit = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) nemit++;
    end
    chk("mid_no_emit", nemit, 0);

    // Random traffic, including requests withdrawn before a grant.
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      bus.req_valid = 4'($urandom) & 4'($urandom_range(0, 15));
      bus.req_a     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.req_b     = $urandom;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (4) @(posedge clk);

    // ops_count wrap.
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    hs = 0;
    seen_ffff = 1'b0;
    for (int t = 0; t < 70000 && hs < 65536; t++) begin
      @(negedge clk);
      if (bus.ops_count == 16'hFFFF) seen_ffff = 1'b1;
      if (bus.rsp_valid && bus.rsp_ready) hs++;
    end
    chk("wrap_handshakes", hs, 65536);
    @(negedge clk);
    chk("wrap_zero", bus.ops_count, 16'h0);
    chk("wrap_seen_ffff", seen_ffff, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bam_mul_arbiter.md
# bam_mul_arbiter

Shares one combinational broken-array approximate multiplier (BAM, carry-save array with ripple-carry final adder) between N_REQ requesters. A round-robin arbiter grants at most one request per cycle, and a two-stage valid/ready pipeline registers the operands and the product. A single tagged response channel returns results. The block sits between accelerator lanes and the approximate arithmetic core, so an area-costly multiplier instance is time-multiplexed rather than replicated.

## Interface
- N_REQ, 4: number of requesters (2..8)
- WIDTH, 8: operand width; product is 2*WIDTH
- H_CUT, 5: horizontal cut; partial-product rows j < H_CUT omitted
- V_CUT, 12: vertical cut; partial products with i+j < V_CUT omitted
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  request valid per requester
- req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- req_a  in  N_REQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand b, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  2*WIDTH  approximate product
- rsp_id  out  $clog2(N_REQ)  index of the originating requester
- ops_count  out  16  count of completed responses (rsp_valid & rsp_ready), wraps at 0xFFFF -> 0

## Operation
- BAM function: rsp_data = sum of (a[i]&b[j]) << (i+j) over all i, j with j >= H_CUT and i+j >= V_CUT. Arithmetic is unsigned, with no truncation beyond the cuts. The result fits in 2*WIDTH bits.
- Stage S1 holds a, b, id and s1_valid. Stage S2 holds the product, id and s2_valid, and drives rsp_*.
- S2 loads when s1_valid and the condition (!s2_valid | rsp_ready) holds.
- S1 loads when the condition (!s1_valid | S2 loads) holds and any req_valid is set.
- Arbitration: round-robin over req_valid starting at pointer rr_ptr.
  - Winner w gets req_ready[w]=1 only in a cycle where S1 loads.
  - On grant, rr_ptr becomes (w+1) mod N_REQ. rr_ptr is unchanged otherwise.
- req_ready depends combinationally on req_valid, rr_ptr and the pipeline state only. It never depends on req_a or req_b.
- Responses leave in acceptance order. rsp_data and rsp_id stay stable while rsp_valid & !rsp_ready.
- A requester may drop req_valid without a grant. No request is lost or duplicated.
- ops_count increments on every rsp handshake.

## Timing
- Reset (async assert, sync deassert in the system): s1_valid=0, s2_valid=0, rr_ptr=0, ops_count=0. Outputs at reset: rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0.
- Latency: request accepted at edge k gives rsp_valid=1 after edge k+1 (two registers, 0 extra bubbles).
- Throughput: 1 result/cycle with rsp_ready held high.
- Full: with s1_valid & s2_valid & !rsp_ready, all req_ready=0.
- Simultaneous events:
  - A rsp handshake and an S1->S2 move in the same cycle keep the pipeline full with no bubble.
  - A new grant in the same cycle refills S1.
- Single requester: with only one requester active, it is granted every cycle the pipeline can accept, regardless of rr_ptr.
- Reset mid-operation: in-flight S1/S2 contents are discarded. No rsp is produced for them, and ops_count clears.

## Structure
- Package bam_mul_pkg:
  - default WIDTH/H_CUT/V_CUT constants
  - typedef of the id width
  - function bam_keep(i,j) returning (j>=H_CUT && i+j>=V_CUT)
- Sub-module bam_mul_core: purely combinational, parameterized by WIDTH/H_CUT/V_CUT. It implements the carry-save array plus ripple-carry final adder, emitting only the kept partial products. The arbiter and pipeline live in the top module.

## Test plan
- Reset then idle: all outputs 0 and ops_count=0. Assert rst_n low mid-stream with S1/S2 full: rsp_valid drops immediately, and nothing is emitted after release.
- Requester 0 only, a=0xFF, b=0xFF: rsp_data=0xB000 and rsp_id=0 two cycles after acceptance. With a=0x80, b=0x80, rsp_data=0x4000. With a=0x0F, b=0xFF, rsp_data=0x0000.
- All 4 requesters valid continuously with rsp_ready=1: grants 0,1,2,3,0,... one per cycle, rsp_id follows the same order, and ops_count=8 after 8 handshakes.
- Backpressure: hold rsp_ready=0 for 5 cycles with all requesters valid.
  - Exactly 2 requests are accepted, then req_ready=0.
  - rsp_data and rsp_id stay stable.
  - On release, the results emerge in order with no loss.
- Random stress against a reference model of bam_keep summation (including req_valid drop before grant and random rsp_ready). Check:
  - per-id result correctness and ordering;
  - ops_count wrap from 0xFFFF to 0.
